// File: rtl/tt_scanner.sv
// tt_scanner: steps an N_IN-bit vector through every combination, holds each
// for DWELL cycles, captures the DUT response f into a truth table and
// compares it against an expected table latched at start.
module tt_scanner #(
  parameter int N_IN  = 2,
  parameter int DWELL = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   f,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        fail_idx
);

  localparam int TBL = 1 << N_IN;
  localparam int CW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TBL-1:0]    table_q, table_d;
  logic [TBL-1:0]    exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              fv_q, fv_d;
  logic [N_IN-1:0]   idx_q, idx_d;

  logic [TBL-1:0]    mismatch;
  logic [N_IN-1:0]   first_idx;

  // Lowest mismatching index: scan downward so the last hit is the lowest.
  always_comb begin
    mismatch  = table_q ^ exp_q;
    first_idx = '0;
    for (int i = TBL - 1; i >= 0; i--) begin
      if (mismatch[i]) first_idx = N_IN'(i);
    end
  end

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;
    fv_d    = fv_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          exp_d   = expected;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
          fv_d    = 1'b0;
          idx_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          table_d[vec_q] = f;
          if (vec_q == VEC_LAST) begin
            state_d = S_CHECK;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        match_d = (mismatch == '0);
        fv_d    = |mismatch;
        idx_d   = first_idx;
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      fv_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      fv_q    <= fv_d;
      idx_q   <= idx_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign match      = match_q;
  assign fail_valid = fv_q;
  assign fail_idx   = idx_q;

endmodule

// File: tb/tb_tt_scanner.sv
// Bench for tt_scanner: a default (DWELL=20) and a DWELL=1 instance share
// start/expected; expected results are queued at start and compared at done.
module tb_tt_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] expected;
  int         f_mode;
  int         sel;

  logic       f0, f1;
  logic [1:0] vec0, vec1, fidx0, fidx1;
  logic       busy0, busy1, done0, done1, match0, match1, fv0, fv1;
  logic [3:0] tbl0, tbl1;

  logic [1:0] vec_o, fidx_o;
  logic       busy_o, done_o, match_o, fv_o;
  logic [3:0] tbl_o;

  typedef struct {
    logic [3:0] tbl;
    logic       m;
    logic       fv;
    logic [1:0] idx;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tt_scanner #(.N_IN(2), .DWELL(20)) u_dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .f(f0),
    .vec(vec0), .busy(busy0), .done(done0), .table_out(tbl0),
    .match(match0), .fail_valid(fv0), .fail_idx(fidx0)
  );

  tt_scanner #(.N_IN(2), .DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .f(f1),
    .vec(vec1), .busy(busy1), .done(done1), .table_out(tbl1),
    .match(match1), .fail_valid(fv1), .fail_idx(fidx1)
  );

  function automatic logic fbit(input int mode, input logic [1:0] v);
    case (mode)
      0:       return v[1] ^ v[0];
      1:       return v[1] & v[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] e, input int mode);
    exp_t r;
    logic [1:0] v;
    r.tbl = '0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      r.tbl[i] = fbit(mode, v);
    end
    r.m   = (r.tbl == e);
    r.fv  = (r.tbl != e);
    r.idx = '0;
    for (int i = 3; i >= 0; i--) if (r.tbl[i] != e[i]) r.idx = 2'(i);
    return r;
  endfunction

  assign f0 = fbit(f_mode, vec0);
  assign f1 = fbit(f_mode, vec1);

  always_comb begin
    if (sel == 1) begin
      vec_o = vec1; busy_o = busy1; done_o = done1; tbl_o = tbl1;
      match_o = match1; fv_o = fv1; fidx_o = fidx1;
    end else begin
      vec_o = vec0; busy_o = busy0; done_o = done0; tbl_o = tbl0;
      match_o = match0; fv_o = fv0; fidx_o = fidx0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive start on the negedge before edge 0; optionally keep it high.
  task automatic start_scan(input logic [3:0] e, input int mode, input bit hold);
    @(negedge clk);
    f_mode   = mode;
    expected = e;
    start    = 1'b1;
    sb.push_back(model(e, mode));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk("start_done_low", {31'd0, done_o}, 32'd0);
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_vec0", {30'd0, vec_o}, 32'd0);
  endtask

  // Count edges from the start edge until done, check vector stepping,
  // then pop the scoreboard and compare the results.
  task automatic wait_done(input int dw, input int exp_edges, input bit busy_pulse);
    int   n;
    exp_t x;
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (busy_pulse && n == 30) start = 1'b1;
      if (busy_pulse && n == 31) start = 1'b0;
      if ((n % dw) == 0 && n < 4 * dw)
        chk($sformatf("vec@%0d", n), {30'd0, vec_o}, 32'(n / dw));
      if (done_o) break;
      if (n >= 1000) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
    chk("done_edge", 32'(n), 32'(exp_edges));
    chk("done_busy", {31'd0, busy_o}, 32'd0);
    chk("done_vec", {30'd0, vec_o}, 32'd3);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk("table_out", {28'd0, tbl_o}, {28'd0, x.tbl});
      chk("match", {31'd0, match_o}, {31'd0, x.m});
      chk("fail_valid", {31'd0, fv_o}, {31'd0, x.fv});
      chk("fail_idx", {30'd0, fidx_o}, {30'd0, x.idx});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; expected = '0; f_mode = 0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {22'd0, vec_o, busy_o, done_o, tbl_o, match_o, fv_o, fidx_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: xor DUT, matching table
    start_scan(4'b0110, 0, 1'b0);
    wait_done(20, 81, 1'b0);
    // 2: xor DUT, mismatch at index 3
    start_scan(4'b1110, 0, 1'b0);
    wait_done(20, 81, 1'b0);
    // 5: restart from DONE with new expected, start pulsed while busy
    start_scan(4'b0111, 0, 1'b0);
    wait_done(20, 81, 1'b1);
    chk("done_held", {31'd0, done_o}, 32'd1);

    // 3: DWELL=1 instance, and DUT
    sel = 1;
    start_scan(4'b1000, 1, 1'b0);
    wait_done(1, 5, 1'b0);
    sel = 0;
    repeat (90) @(posedge clk);

    // 4: reset mid-scan at edge 45
    @(negedge clk);
    f_mode = 0; expected = 4'b0110; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (45) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", {22'd0, vec_o, busy_o, done_o, tbl_o, match_o, fv_o, fidx_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_scan(4'b0110, 0, 1'b0);
    wait_done(20, 81, 1'b0);

    // 6: f tied high, start held high -> one-cycle done, immediate restart
    start_scan(4'b1111, 2, 1'b1);
    wait_done(20, 81, 1'b0);
    sb.push_back(model(4'b1111, 2));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hold_done_low", {31'd0, done_o}, 32'd0);
    chk("hold_busy", {31'd0, busy_o}, 32'd1);
    chk("hold_vec0", {30'd0, vec_o}, 32'd0);
    wait_done(20, 81, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
